// File: rtl/cmos_pkg.sv
// Shared types and constants for the OV5640 pixel capture path.
package cmos_pkg;

    localparam int unsigned XW = 11;
    localparam int unsigned YW = 10;
    localparam int unsigned FW = 8;

    localparam int unsigned DefHActive = 1024;
    localparam int unsigned DefVActive = 768;

    typedef logic [1:0] state_t;

    localparam state_t StIdle   = 2'd0;
    localparam state_t StWaitVs = 2'd1;
    localparam state_t StSkip   = 2'd2;
    localparam state_t StActive = 2'd3;

endpackage

// File: rtl/edge_det.sv
// Rise/fall detector: compares a registered input against its own one-cycle delay.
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic sig_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q;
    assign fall = ~sig & sig_q;

endmodule

// File: rtl/cmos_pixel_packer.sv
// Packs the sensor's RGB565 byte stream into 16-bit pixel strobes, dropping start-up frames
// and tracking pixel/line position and malformed lines.
module cmos_pixel_packer
    import cmos_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = DefHActive,
    parameter int unsigned V_ACTIVE    = DefVActive,
    parameter int unsigned SKIP_FRAMES = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          init_done,
    input  logic          cmos_vsync,
    input  logic          cmos_href,
    input  logic [7:0]    cmos_data,
    output logic          pix_we,
    output logic [15:0]   pix_data,
    output logic          frame_valid,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic [FW-1:0] frame_cnt,
    output logic          line_err
);

    if (H_ACTIVE < 1 || H_ACTIVE > 2047 || V_ACTIVE > 1024 || SKIP_FRAMES > 255)
    begin : g_bad_params
        $error("cmos_pixel_packer: parameter out of range");
    end

    localparam logic [11:0] LineBytes = 12'(2 * H_ACTIVE);
    localparam logic [7:0]  SkipLim   = 8'(SKIP_FRAMES);

    logic        vs_q, hr_q;
    logic [7:0]  d_q;
    logic        vs_rise, vs_fall, hr_rise, hr_fall;

    state_t      state_q, state_d;
    logic [7:0]  skip_q, skip_d;
    logic        frame_end;

    logic        phase_q, phase_d;
    logic [7:0]  hi_q, hi_d;
    logic [11:0] byte_cnt_q, byte_cnt_d;
    logic        active;

    logic          pix_we_d;
    logic [15:0]   pix_data_d;
    logic          frame_valid_d;
    logic [XW-1:0] pix_x_d;
    logic [YW-1:0] pix_y_d;
    logic [FW-1:0] frame_cnt_d;
    logic          line_err_d;

    edge_det u_vs_edge (
        .clk  (clk),
        .rst  (rst),
        .sig  (vs_q),
        .rise (vs_rise),
        .fall (vs_fall)
    );

    edge_det u_hr_edge (
        .clk  (clk),
        .rst  (rst),
        .sig  (hr_q),
        .rise (hr_rise),
        .fall (hr_fall)
    );

    always_comb begin
        state_d   = state_q;
        skip_d    = skip_q;
        frame_end = 1'b0;
        if (!init_done) begin
            state_d = StIdle;
            skip_d  = '0;
        end else begin
            case (state_q)
                StIdle:   state_d = StWaitVs;
                StWaitVs: begin
                    if (vs_fall) begin
                        state_d = (skip_q < SkipLim) ? StSkip : StActive;
                    end
                end
                StSkip: begin
                    if (vs_rise) begin
                        state_d = StWaitVs;
                        skip_d  = skip_q + 8'd1;
                    end
                end
                StActive: begin
                    if (vs_rise) begin
                        state_d   = StWaitVs;
                        frame_end = 1'b1;
                    end
                end
                default:  state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        active = init_done && (state_q == StActive);

        // Frame start wins over a byte arriving in the same cycle: phase restarts at 0.
        phase_d = hr_q && !vs_fall && !phase_q;
        hi_d    = (hr_q && !phase_q && !vs_fall) ? d_q : hi_q;

        pix_we_d   = active && hr_q && phase_q && !vs_rise && !vs_fall;
        pix_data_d = pix_we_d ? {hi_q, d_q} : pix_data;

        byte_cnt_d = byte_cnt_q;
        if (vs_fall) begin
            byte_cnt_d = '0;
        end else if (hr_rise) begin
            byte_cnt_d = 12'd1;
        end else if (hr_q && (byte_cnt_q != '1)) begin
            byte_cnt_d = byte_cnt_q + 12'd1;
        end

        line_err_d = active && hr_fall && (byte_cnt_q != LineBytes);

        pix_x_d = pix_x;
        if (vs_fall || hr_fall) begin
            pix_x_d = '0;
        end else if (pix_we && (pix_x != '1)) begin
            pix_x_d = pix_x + XW'(1);
        end

        pix_y_d = pix_y;
        if (vs_fall) begin
            pix_y_d = '0;
        end else if (hr_fall && (byte_cnt_q != '0) && (pix_y != '1)) begin
            pix_y_d = pix_y + YW'(1);
        end

        frame_cnt_d   = frame_end ? frame_cnt + FW'(1) : frame_cnt;
        frame_valid_d = (state_d == StActive);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_q        <= 1'b0;
            hr_q        <= 1'b0;
            d_q         <= '0;
            state_q     <= StIdle;
            skip_q      <= '0;
            phase_q     <= 1'b0;
            hi_q        <= '0;
            byte_cnt_q  <= '0;
            pix_we      <= 1'b0;
            pix_data    <= '0;
            frame_valid <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_cnt   <= '0;
            line_err    <= 1'b0;
        end else begin
            vs_q        <= cmos_vsync;
            hr_q        <= cmos_href;
            d_q         <= cmos_data;
            state_q     <= state_d;
            skip_q      <= skip_d;
            phase_q     <= phase_d;
            hi_q        <= hi_d;
            byte_cnt_q  <= byte_cnt_d;
            pix_we      <= pix_we_d;
            pix_data    <= pix_data_d;
            frame_valid <= frame_valid_d;
            pix_x       <= pix_x_d;
            pix_y       <= pix_y_d;
            frame_cnt   <= frame_cnt_d;
            line_err    <= line_err_d;
        end
    end

endmodule

// File: tb/tb_cmos_pixel_packer.sv
// Directed bench for cmos_pixel_packer with 4x2 frames and two skipped start-up frames.
module tb_cmos_pixel_packer;

    localparam int unsigned H  = 4;
    localparam int unsigned V  = 2;
    localparam int unsigned SK = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_done;
    logic        cmos_vsync;
    logic        cmos_href;
    logic [7:0]  cmos_data;
    logic        pix_we;
    logic [15:0] pix_data;
    logic        frame_valid;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;
    logic [7:0]  frame_cnt;
    logic        line_err;

    always #5 clk = ~clk;

    cmos_pixel_packer #(
        .H_ACTIVE    (H),
        .V_ACTIVE    (V),
        .SKIP_FRAMES (SK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .init_done   (init_done),
        .cmos_vsync  (cmos_vsync),
        .cmos_href   (cmos_href),
        .cmos_data   (cmos_data),
        .pix_we      (pix_we),
        .pix_data    (pix_data),
        .frame_valid (frame_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .frame_cnt   (frame_cnt),
        .line_err    (line_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    int   q_data[$];
    int   q_x[$];
    int   q_y[$];
    int   q_cyc[$];
    int   le_cyc[$];
    int   fv_rise[$];
    int   fv_fall[$];
    int   back2back = 0;
    logic we_prev = 1'b0;
    logic fv_prev = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (pix_we) begin
                q_data.push_back(int'(pix_data));
                q_x.push_back(int'(pix_x));
                q_y.push_back(int'(pix_y));
                q_cyc.push_back(cyc);
                if (we_prev) back2back <= back2back + 1;
            end
            if (line_err) le_cyc.push_back(cyc);
            if (frame_valid && !fv_prev) fv_rise.push_back(cyc);
            if (!frame_valid && fv_prev) fv_fall.push_back(cyc);
        end
        we_prev <= pix_we;
        fv_prev <= frame_valid;
    end

    function automatic int at(input int q[$], input int i);
        return (i >= 0 && i < q.size()) ? q[i] : -1;
    endfunction

    function automatic int last(input int q[$]);
        return (q.size() > 0) ? q[q.size()-1] : -1;
    endfunction

    task automatic clear_q();
        q_data.delete();
        q_x.delete();
        q_y.delete();
        q_cyc.delete();
        le_cyc.delete();
        fv_rise.delete();
        fv_fall.delete();
    endtask

    int vs_fall_cyc, vs_rise_cyc, hr_fall_cyc, mark_cyc;

    // Inputs change just after a rising edge, like the sensor launching on PCLK.
    task automatic drive(input logic vs, input logic hr, input logic [7:0] d);
        @(posedge clk);
        #1;
        cmos_vsync = vs;
        cmos_href  = hr;
        cmos_data  = d;
    endtask

    task automatic line(input int nbytes, input logic [7:0] first);
        for (int i = 0; i < nbytes; i++) drive(1'b0, 1'b1, first + 8'(i));
        drive(1'b0, 1'b0, 8'h00);
        hr_fall_cyc = cyc;
        repeat (3) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic frame_open();
        repeat (3) drive(1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        vs_fall_cyc = cyc;
        repeat (2) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic frame_close();
        drive(1'b1, 1'b0, 8'h00);
        vs_rise_cyc = cyc;
        repeat (3) drive(1'b1, 1'b0, 8'h00);
    endtask

    task automatic std_frame();
        frame_open();
        line(8, 8'h01);
        line(8, 8'h09);
        frame_close();
    endtask

    task automatic short_frame();
        repeat (2) drive(1'b1, 1'b0, 8'h00);
        repeat (2) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_we"},   32'(pix_we),      0);
        check({pfx, "_data"}, 32'(pix_data),    0);
        check({pfx, "_fv"},   32'(frame_valid), 0);
        check({pfx, "_x"},    32'(pix_x),       0);
        check({pfx, "_y"},    32'(pix_y),       0);
        check({pfx, "_fcnt"}, 32'(frame_cnt),   0);
        check({pfx, "_lerr"}, 32'(line_err),    0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        init_done  = 1'b0;
        cmos_vsync = 1'b1;
        cmos_href  = 1'b0;
        cmos_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst       = 1'b0;
        init_done = 1'b1;
        repeat (3) drive(1'b1, 1'b0, 8'h00);

        // Two start-up frames dropped, third one output.
        clear_q();
        std_frame();
        std_frame();
        check("skip_we_count", q_data.size(), 0);
        check("skip_fv_rises", fv_rise.size(), 0);
        clear_q();
        std_frame();
        check("f3_we_count", q_data.size(), 8);
        check("f3_first_data", at(q_data, 0), 32'h0102);
        check("f3_last_data", last(q_data), 32'h0F10);
        check("f3_px3_x", at(q_x, 3), 3);
        check("f3_px4_x", at(q_x, 4), 0);
        check("f3_px4_y", at(q_y, 4), 1);
        check("f3_line_err", le_cyc.size(), 0);
        check("f3_frame_cnt", frame_cnt, 1);
        check("f3_fv_rise_lat", last(fv_rise) - vs_fall_cyc, 2);
        check("f3_fv_fall_lat", last(fv_fall) - vs_rise_cyc, 2);

        // Single pixel latency.
        clear_q();
        frame_open();
        drive(1'b0, 1'b1, 8'hAB);
        drive(1'b0, 1'b1, 8'hCD);
        mark_cyc = cyc;
        repeat (3) drive(1'b0, 1'b0, 8'h00);
        frame_close();
        check("lat_we_count", q_data.size(), 1);
        check("lat_cycles", at(q_cyc, 0) - mark_cyc, 2);
        check("lat_data", at(q_data, 0), 32'hABCD);
        check("lat_x", at(q_x, 0), 0);
        check("lat_y", at(q_y, 0), 0);
        check("lat_frame_cnt", frame_cnt, 2);

        // Odd-length line then a well-formed line.
        clear_q();
        frame_open();
        line(7, 8'h20);
        mark_cyc = hr_fall_cyc;
        line(8, 8'h30);
        frame_close();
        check("odd_we_count", q_data.size(), 7);
        check("odd_err_count", le_cyc.size(), 1);
        check("odd_err_lat", at(le_cyc, 0) - mark_cyc, 2);
        check("odd_px2_data", at(q_data, 2), 32'h2425);
        check("odd_l2_first", at(q_data, 3), 32'h3031);
        check("odd_l2_y", at(q_y, 3), 1);
        check("odd_l2_last_x", last(q_x), 3);
        check("odd_frame_cnt", frame_cnt, 3);

        // init_done drops mid-line.
        clear_q();
        frame_open();
        drive(1'b0, 1'b1, 8'h40);
        drive(1'b0, 1'b1, 8'h41);
        drive(1'b0, 1'b1, 8'h42);
        @(posedge clk);
        #1;
        init_done = 1'b0;
        cmos_data = 8'h43;
        mark_cyc  = cyc;
        drive(1'b0, 1'b1, 8'h44);
        drive(1'b0, 1'b1, 8'h45);
        repeat (3) drive(1'b0, 1'b0, 8'h00);
        check("drop_we_count", q_data.size(), 1);
        check("drop_data", at(q_data, 0), 32'h4041);
        check("drop_fv_lat", last(fv_fall) - mark_cyc, 1);
        check("drop_frame_cnt", frame_cnt, 3);
        @(posedge clk);
        #1;
        init_done = 1'b1;
        clear_q();
        std_frame();
        std_frame();
        check("reskip_we_count", q_data.size(), 0);
        std_frame();
        check("reinit_we_count", q_data.size(), 8);
        check("reinit_frame_cnt", frame_cnt, 4);

        // vsync rises while href is still high.
        clear_q();
        frame_open();
        for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, 8'h50 + 8'(i));
        drive(1'b1, 1'b1, 8'h57);
        vs_rise_cyc = cyc;
        drive(1'b1, 1'b1, 8'h58);
        drive(1'b1, 1'b1, 8'h59);
        repeat (4) drive(1'b1, 1'b0, 8'h00);
        check("early_we_count", q_data.size(), 3);
        check("early_last_data", last(q_data), 32'h5455);
        check("early_line_err", le_cyc.size(), 0);
        check("early_frame_cnt", frame_cnt, 5);
        check("early_fv_fall_lat", last(fv_fall) - vs_rise_cyc, 2);

        // Asynchronous reset in the middle of a frame.
        frame_open();
        drive(1'b0, 1'b1, 8'h60);
        drive(1'b0, 1'b1, 8'h61);
        drive(1'b0, 1'b1, 8'h62);
        drive(1'b0, 1'b1, 8'h63);
        #2;
        rst = 1'b1;
        #1;
        check_zero("arst");
        @(posedge clk);
        #1;
        rst        = 1'b0;
        cmos_href  = 1'b0;
        cmos_vsync = 1'b1;

        // frame_cnt wraps after 256 output frames.
        repeat (2) short_frame();
        short_frame();
        repeat (3) drive(1'b1, 1'b0, 8'h00);
        check("wrap_cnt_1", frame_cnt, 1);
        repeat (254) short_frame();
        repeat (3) drive(1'b1, 1'b0, 8'h00);
        check("wrap_cnt_255", frame_cnt, 255);
        short_frame();
        repeat (3) drive(1'b1, 1'b0, 8'h00);
        check("wrap_cnt_0", frame_cnt, 0);

        check("we_back_to_back", back2back, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
